// File: rtl/grover_diffusion_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// grover_diffusion_ctrl_pkg
// Shared definitions for the Grover diffusion sequencer:
//   - state_t    : sequencer states IDLE, SUM, MEAN, REFLECT, DONE
//   - num_amps   : N = 2^NUM_QUBIT amplitude count
//   - acc_width  : ACC_WIDTH = DATA_WIDTH + NUM_QUBIT (cannot overflow over N terms)
//   - reduce_dw  : narrows a wide signed value to DATA_WIDTH bits
// Build option: define DIFFUSION_SAT_EN to saturate on narrowing; otherwise
// the value wraps (two's-complement truncation).
// ---------------------------------------------------------------------------
package grover_diffusion_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_MEAN,
    ST_REFLECT,
    ST_DONE
  } state_t;

  // Working width for the narrowing helper; DATA_WIDTH + NUM_QUBIT must fit.
  localparam int RED_W = 64;

  function automatic int num_amps(input int nq);
    return 1 << nq;
  endfunction

  function automatic int acc_width(input int nq, input int dw);
    return dw + nq;
  endfunction

  // Result is meaningful in its low dw bits; callers size-cast it.
  function automatic logic signed [RED_W-1:0] reduce_dw(input logic signed [RED_W-1:0] v,
                                                        input int dw);
`ifdef DIFFUSION_SAT_EN
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    // Keep the low dw bits and re-sign-extend them: two's-complement wrap.
    return (v <<< (RED_W - dw)) >>> (RED_W - dw);
`endif
  endfunction

endpackage

// File: rtl/grover_diffusion_ctrl_if.sv
// ---------------------------------------------------------------------------
// grover_diffusion_ctrl_if
// Control handshake plus amplitude-memory port of the diffusion sequencer.
//   start   : run request from the Grover iteration FSM
//   busy    : sequencer running
//   done    : one-cycle completion pulse
//   rd_en / rd_addr / rd_data : memory read, data valid one cycle after rd_en
//   wr_en / wr_addr / wr_data : memory write
// modport master : the sequencer; modport slave : host FSM + memory side.
// ---------------------------------------------------------------------------
interface grover_diffusion_ctrl_if #(
  parameter int NUM_QUBIT  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [NUM_QUBIT-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [NUM_QUBIT-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/grover_diffusion_ctrl_diffusion_lane.sv
// ---------------------------------------------------------------------------
// diffusion_lane
// One scalar lane of the broadcast subtractor: diff = m2 - amp, formed in
// DATA_WIDTH+1 bits, then narrowed to DATA_WIDTH (saturate when
// DIFFUSION_SAT_EN is defined, wrap otherwise). Purely combinational.
//   m2   : input  DATA_WIDTH  2*mean
//   amp  : input  DATA_WIDTH  amplitude read from memory
//   diff : output DATA_WIDTH  reflected amplitude
// ---------------------------------------------------------------------------
module diffusion_lane
  import grover_diffusion_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] m2,
  input  logic signed [DATA_WIDTH-1:0] amp,
  output logic signed [DATA_WIDTH-1:0] diff
);

  logic signed [DATA_WIDTH:0] wide;

  assign wide = {m2[DATA_WIDTH-1], m2} - {amp[DATA_WIDTH-1], amp};
  assign diff = DATA_WIDTH'(reduce_dw(RED_W'(wide), DATA_WIDTH));

endmodule

// File: rtl/grover_diffusion_ctrl.sv
// ---------------------------------------------------------------------------
// grover_diffusion_ctrl
// Sequencer for the Grover "inversion about the mean" step. A sum pass reads
// all N = 2^NUM_QUBIT amplitudes and accumulates them, MEAN forms
// m2 = sum >>> (NUM_QUBIT-1) (= 2*mean, floor), and a reflect pass re-reads
// every amplitude and writes m2 - amp back to the same address.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : grover_diffusion_ctrl_if.master (start/busy/done + memory port)
// Build option: DIFFUSION_SAT_EN selects saturating narrowing of m2 and
// wr_data; without it both wrap to DATA_WIDTH bits.
// ---------------------------------------------------------------------------
module grover_diffusion_ctrl
  import grover_diffusion_ctrl_pkg::*;
#(
  parameter int NUM_QUBIT  = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  grover_diffusion_ctrl_if.master bus
);

  localparam int N         = num_amps(NUM_QUBIT);
  localparam int ACC_WIDTH = acc_width(NUM_QUBIT, DATA_WIDTH);
  localparam logic [NUM_QUBIT-1:0] ADDR_LAST = NUM_QUBIT'(N - 1);

  state_t                        state;
  logic                          rd_pend;   // rd_data valid this cycle
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]  m2;
  logic signed [DATA_WIDTH-1:0]  m2_next;
  logic signed [DATA_WIDTH-1:0]  lane_diff;

  always_comb begin
    m2_next = DATA_WIDTH'(reduce_dw(RED_W'(acc) >>> (NUM_QUBIT - 1), DATA_WIDTH));
  end

  diffusion_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .m2   (m2),
    .amp  (bus.rd_data),
    .diff (lane_diff)
  );

  // NOTE: wr_data is combinational from rd_data because the write must land
  // in the same cycle the read data arrives; gating with the registered
  // wr_en keeps it at 0 outside writes and drops it at once on reset.
  assign bus.wr_data = bus.wr_en ? lane_diff : '0;

  // NOTE: all state is updated with non-blocking assignments so every read
  // below sees the value from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      rd_pend     <= 1'b0;
      acc         <= '0;
      m2          <= '0;
    end else begin
      rd_pend     <= bus.rd_en;
      bus.done    <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state       <= ST_SUM;
            bus.busy    <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
            acc         <= '0;
          end
        end
        ST_SUM: begin
          if (rd_pend) acc <= acc + ACC_WIDTH'($signed(bus.rd_data));
          if (bus.rd_en) begin
            if (bus.rd_addr == ADDR_LAST) begin
              bus.rd_en   <= 1'b0;
              bus.rd_addr <= '0;
            end else begin
              bus.rd_addr <= bus.rd_addr + NUM_QUBIT'(1);
            end
          end else begin
            // Drain cycle: last read data has just been accumulated.
            state <= ST_MEAN;
          end
        end
        ST_MEAN: begin
          m2          <= m2_next;
          state       <= ST_REFLECT;
          bus.rd_en   <= 1'b1;
          bus.rd_addr <= '0;
        end
        ST_REFLECT: begin
          // Each write trails its read by one cycle, same address.
          bus.wr_en   <= bus.rd_en;
          bus.wr_addr <= bus.rd_addr;
          if (bus.rd_en) begin
            if (bus.rd_addr == ADDR_LAST) begin
              bus.rd_en   <= 1'b0;
              bus.rd_addr <= '0;
            end else begin
              bus.rd_addr <= bus.rd_addr + NUM_QUBIT'(1);
            end
          end else begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grover_diffusion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grover_diffusion_ctrl
// Bench for grover_diffusion_ctrl with NUM_QUBIT = 2 (N = 4), one instance at
// DATA_WIDTH = 32 and one at DATA_WIDTH = 8, each with a small memory model.
// Honours DIFFUSION_SAT_EN in its expected values.
// ---------------------------------------------------------------------------
module tb_grover_diffusion_ctrl;

  localparam int NQ = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grover_diffusion_ctrl_if #(.NUM_QUBIT(NQ), .DATA_WIDTH(32)) b32 ();
  grover_diffusion_ctrl_if #(.NUM_QUBIT(NQ), .DATA_WIDTH(8))  b8 ();

  grover_diffusion_ctrl #(.NUM_QUBIT(NQ), .DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.master));
  grover_diffusion_ctrl #(.NUM_QUBIT(NQ), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.master));

  logic [31:0] mem32 [N];
  logic [7:0]  mem8  [N];

  always @(posedge clk) begin
    if (b32.rd_en) b32.rd_data <= mem32[b32.rd_addr];
    if (b32.wr_en) mem32[b32.wr_addr] <= b32.wr_data;
    if (b8.rd_en)  b8.rd_data  <= mem8[b8.rd_addr];
    if (b8.wr_en)  mem8[b8.wr_addr]   <= b8.wr_data;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic   busy, done, rd_en, wr_en;
    int     rd_addr, wr_addr;
    longint wr_data;
  } obs_t;

  typedef struct {
    int     cyc;
    int     addr;
    longint data;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  int  busy_n;
  int  busy_first;

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.busy = b32.busy; o.done = b32.done; o.rd_en = b32.rd_en; o.wr_en = b32.wr_en;
      o.rd_addr = int'(b32.rd_addr); o.wr_addr = int'(b32.wr_addr);
      o.wr_data = longint'($signed(b32.wr_data));
    end else begin
      o.busy = b8.busy; o.done = b8.done; o.rd_en = b8.rd_en; o.wr_en = b8.wr_en;
      o.rd_addr = int'(b8.rd_addr); o.wr_addr = int'(b8.wr_addr);
      o.wr_data = longint'($signed(b8.wr_data));
    end
    return o;
  endfunction

  function automatic longint get_m2(input int sel);
    return (sel == 0) ? longint'($signed(dut32.m2)) : longint'($signed(dut8.m2));
  endfunction

  function automatic longint get_mem(input int sel, input int i);
    return (sel == 0) ? longint'($signed(mem32[i])) : longint'($signed(mem8[i]));
  endfunction

  task automatic load_mem(input int sel, input longint m [N]);
    for (int i = 0; i < N; i++) begin
      if (sel == 0) mem32[i] = 32'(m[i]);
      else          mem8[i]  = 8'(m[i]);
    end
  endtask

  // Runs ncyc cycles; relative cycle k is the one whose start value is set at
  // its falling edge (k = 0 is the accepted start). Outputs are sampled at
  // that falling edge before driving. Optional second start pulse and reset.
  task automatic run_one(input int sel, input int pulse2, input int rst_at, input int ncyc);
    obs_t o;
    rd_q.delete(); wr_q.delete(); done_q.delete();
    busy_n = 0; busy_first = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      o = observe(sel);
      if (o.busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = k;
      end
      if (o.done)  done_q.push_back(k);
      if (o.rd_en) rd_q.push_back(ev_t'{k, o.rd_addr, 0});
      if (o.wr_en) wr_q.push_back(ev_t'{k, o.wr_addr, o.wr_data});
      if (sel == 0) b32.start = (k == 0 || k == pulse2);
      else          b8.start  = (k == 0 || k == pulse2);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        o = observe(sel);
        check("rst_wr_en", longint'(o.wr_en), 0);
        check("rst_rd_en", longint'(o.rd_en), 0);
        check("rst_busy", longint'(o.busy), 0);
        check("rst_wr_data", o.wr_data, 0);
      end
    end
    b32.start = 1'b0;
    b8.start  = 1'b0;
  endtask

  // Checks a single normal run against expected writes and m2.
  task automatic check_run(input string tag, input int sel, input longint exp_m2,
                           input longint exp_wr [N]);
    check({tag, ":done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, ":done_cycle"}, done_q[0], 2 * N + 4);
    check({tag, ":busy_cycles"}, busy_n, 2 * N + 4);
    check({tag, ":busy_first"}, busy_first, 1);
    check({tag, ":rd_count"}, rd_q.size(), 2 * N);
    for (int i = 0; i < rd_q.size() && i < 2 * N; i++) begin
      check({tag, ":rd_cycle"}, rd_q[i].cyc, (i < N) ? 1 + i : N + 3 + (i - N));
      check({tag, ":rd_addr"}, rd_q[i].addr, i % N);
    end
    check({tag, ":wr_count"}, wr_q.size(), N);
    for (int i = 0; i < wr_q.size() && i < N; i++) begin
      check({tag, ":wr_cycle"}, wr_q[i].cyc, N + 4 + i);
      check({tag, ":wr_addr"}, wr_q[i].addr, i);
      check({tag, ":wr_data"}, wr_q[i].data, exp_wr[i]);
    end
    check({tag, ":m2"}, get_m2(sel), exp_m2);
    for (int i = 0; i < N; i++) check({tag, ":mem"}, get_mem(sel, i), exp_wr[i]);
  endtask

  // ---------------- reference model ----------------
  function automatic longint fit(input longint x, input int dw);
    longint lo, hi, span, r;
    lo   = -(longint'(1) << (dw - 1));
    hi   = (longint'(1) << (dw - 1)) - 1;
    span = longint'(1) << dw;
`ifdef DIFFUSION_SAT_EN
    r = (x < lo) ? lo : (x > hi) ? hi : x;
`else
    r = (x - lo) % span;
    if (r < 0) r += span;
    r = r + lo;
`endif
    return r;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic model(input int dw, input longint m [N], output longint m2,
                       output longint w [N]);
    longint sum = 0;
    for (int i = 0; i < N; i++) sum += m[i];
    m2 = fit(floor_div(2 * sum, N), dw);
    for (int i = 0; i < N; i++) w[i] = fit(m2 - m[i], dw);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string  name;
    int     sel;
    longint mem [N];
    longint exp_m2;
    longint exp_wr [N];
  } vec_t;

  vec_t vecs [5];

  initial begin
    longint m [N];
    longint w [N];
    longint em2;
    longint orig [N];

    vecs[0] = '{"grover",  0, '{10, 10, 10, -6}, 12, '{2, 2, 2, 18}};
    vecs[1] = '{"uniform", 0, '{5, 5, 5, 5},     10, '{5, 5, 5, 5}};
`ifdef DIFFUSION_SAT_EN
    vecs[2] = '{"ovf8",    1, '{127, 127, 127, -128}, 126, '{-1, -1, -1, 127}};
    vecs[4] = '{"m2_ovf8", 1, '{-128, -128, -128, -128}, -128, '{0, 0, 0, 0}};
`else
    vecs[2] = '{"ovf8",    1, '{127, 127, 127, -128}, 126, '{-1, -1, -1, -2}};
    vecs[4] = '{"m2_ovf8", 1, '{-128, -128, -128, -128}, 0, '{-128, -128, -128, -128}};
`endif
    vecs[3] = '{"floor",   0, '{-3, -4, 0, 0},   -4, '{-1, 0, -4, -4}};

    b32.start = 1'b0;
    b8.start  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:busy",    longint'(b32.busy), 0);
    check("reset:done",    longint'(b32.done), 0);
    check("reset:rd_en",   longint'(b32.rd_en), 0);
    check("reset:wr_en",   longint'(b32.wr_en), 0);
    check("reset:rd_addr", longint'(b32.rd_addr), 0);
    check("reset:wr_addr", longint'(b32.wr_addr), 0);
    check("reset:wr_data", longint'(b32.wr_data), 0);
    check("reset:m2",      get_m2(0), 0);
    check("reset8:busy",   longint'(b8.busy), 0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].sel, vecs[v].mem);
      run_one(vecs[v].sel, -1, -1, 2 * N + 8);
      check_run(vecs[v].name, vecs[v].sel, vecs[v].exp_m2, vecs[v].exp_wr);
    end

    // Randomized memories against the model, both widths.
    for (int r = 0; r < 16; r++) begin
      int sel = r % 2;
      for (int i = 0; i < N; i++) begin
        if (sel == 0)
          m[i] = ($urandom_range(0, 1) == 0) ? longint'($signed(32'($urandom)))
                                             : longint'($urandom_range(0, 40)) - 20;
        else
          m[i] = longint'($signed(8'($urandom)));
      end
      model(sel == 0 ? 32 : 8, m, em2, w);
      load_mem(sel, m);
      run_one(sel, -1, -1, 2 * N + 8);
      check_run("random", sel, em2, w);
    end

    // start pulsed again while busy: ignored.
    orig = '{10, 10, 10, -6};
    load_mem(0, orig);
    run_one(0, 5, -1, 2 * N + 8);
    check_run("start_busy", 0, 12, '{2, 2, 2, 18});

    // Reset during the first reflect write cycle.
    load_mem(0, orig);
    run_one(0, -1, N + 4, N + 6);
    for (int i = 0; i < N; i++) check("rst_mem_untouched", get_mem(0, i), orig[i]);
    rst_n = 1'b1;
    run_one(0, -1, -1, 2 * N + 8);
    check_run("after_rst", 0, 12, '{2, 2, 2, 18});

    // Back-to-back runs: second run restores the original memory.
    load_mem(0, orig);
    run_one(0, 2 * N + 5, -1, 4 * N + 12);
    check("b2b:done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("b2b:done0", done_q[0], 2 * N + 4);
      check("b2b:done1", done_q[1], 4 * N + 9);
    end
    check("b2b:wr_count", wr_q.size(), 2 * N);
    for (int i = N; i < wr_q.size() && i < 2 * N; i++) begin
      check("b2b:wr_cycle", wr_q[i].cyc, 3 * N + 9 + (i - N));
      check("b2b:wr_addr",  wr_q[i].addr, i - N);
      check("b2b:wr_data",  wr_q[i].data, orig[i - N]);
    end
    check("b2b:m2", get_m2(0), 12);
    for (int i = 0; i < N; i++) check("b2b:mem", get_mem(0, i), orig[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
